// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Defaults size a 64KB instruction ROM fed from a little-endian byte stream.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int LEN_W_DEF  = 16;
    localparam int DATA_BYTES = 4;
    localparam int BCNT_W     = $clog2(DATA_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Byte counter plus 32-bit shift register: bytes enter at the top so the
// first byte of a group ends up in word_o[7:0] once the group is complete.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;

    // NOTE: every always_comb output gets its hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en) begin
            cnt_d   = cnt_q + BCNT_W'(1);
            shift_d = {byte_i, shift_q[31:8]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_o = shift_q;
    assign last_o = byte_en && (cnt_q == BCNT_W'(DATA_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: reads a 16-bit little-endian word count, then packs bytes
// into 32-bit words and writes them to instruction memory while holding the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    prog_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int CMP_W = (LEN_W > IDX_W) ? LEN_W : IDX_W;
    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [31:0]       wdata_hold_q, wdata_hold_d;

    logic              rx_ready;
    logic              rx_fire;
    logic              mem_we;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_bad;
    logic              last_word;
    logic [31:0]       word;
    logic              word_last;

    assign rx_ready = state_q inside {LEN0, LEN1, DATA};
    assign rx_fire  = bus.rx_valid && rx_ready;
    assign mem_we   = (state_q == WRITE);

    // Full count as it will be once the high byte in LEN1 is accepted.
    assign hdr_len   = LEN_W'({bus.rx_data, count_q[7:0]});
    assign hdr_bad   = (hdr_len == '0) || (CMP_W'(hdr_len) > MAX_WORDS);
    // Index is one bit wider than the address so a full ROM load never wraps.
    assign last_word = (CMP_W'(idx_q) + CMP_W'(1)) == CMP_W'(count_q);

    word_assembler u_word_assembler (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == IDLE && start),
        .byte_en (rx_fire && state_q == DATA),
        .byte_i  (bus.rx_data),
        .word_o  (word),
        .last_o  (word_last)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        err_d        = err_q;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEN0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            LEN0: begin
                if (rx_fire) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = LEN1;
                end
            end
            LEN1: begin
                if (rx_fire) begin
                    count_d = hdr_len;
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_last) state_d = WRITE;
            end
            WRITE: begin
                idx_d        = idx_q + IDX_W'(1);
                addr_hold_d  = idx_q[ADDR_W-1:0];
                wdata_hold_d = word;
                state_d      = last_word ? DONE : DATA;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    // Live values during WRITE, last written values at all other times.
    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_we ? idx_q[ADDR_W-1:0] : addr_hold_q;
    assign bus.mem_wdata = mem_we ? word : wdata_hold_q;

    assign busy     = (state_q != IDLE);
    assign cpu_hold = busy;
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning the instruction-memory word-address width (64KB ROM, 16384 words).
REQ-002 The block SHALL have parameter LEN_W, default 16, meaning the width of the word-count header.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 Port clock: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-006 Port start: input, 1 bit, single-cycle request to begin a load.
REQ-007 Port rx_valid: input, 1 bit, the byte source has a byte on rx_data.
REQ-008 Port rx_data: input, 8 bits, byte-stream payload.
REQ-009 Port rx_ready: output, 1 bit, loader accepts a byte this cycle.
REQ-010 Port mem_we: output, 1 bit, instruction-memory write strobe.
REQ-011 Port mem_addr: output, ADDR_W bits, word address of the write.
REQ-012 Port mem_wdata: output, 32 bits, instruction word to write.
REQ-013 Port cpu_hold: output, 1 bit, holds the fetch unit/CPU in reset while loading.
REQ-014 Port busy: output, 1 bit, load in progress.
REQ-015 Port done: output, 1 bit, one-cycle pulse on successful completion.
REQ-016 Port err: output, 1 bit, sticky error flag for a bad header.

Function
REQ-017 FSM states SHALL be IDLE, LEN0, LEN1, DATA, WRITE and DONE.
REQ-018 IDLE: start=1 SHALL go to LEN0, clear err and clear the word index; start SHALL be ignored in every other state.
REQ-019 A byte transfers only when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-020 rx_ready SHALL be 1 only in LEN0, LEN1 and DATA.
REQ-021 LEN0 SHALL capture the transferred byte as count[7:0]; LEN1 SHALL capture count[15:8] (little-endian).
REQ-022 After LEN1, count=0 or count>2^ADDR_W SHALL set err and return to IDLE with no memory write; otherwise the FSM SHALL go to DATA.
REQ-023 DATA SHALL pack bytes little-endian: the first byte goes to word[7:0] and the fourth to word[31:24].
REQ-024 After the fourth byte transfers, the FSM SHALL enter WRITE on the next cycle.
REQ-025 WRITE SHALL drive mem_we=1 for exactly one cycle, with mem_addr equal to the word index and mem_wdata equal to the packed word.
REQ-026 After WRITE, the word index SHALL increment; if the written index equals count-1 the FSM goes to DONE, else back to DATA.
REQ-027 Word-index arithmetic SHALL be ADDR_W+1 bits wide so that count=2^ADDR_W terminates correctly with no wrap.
REQ-028 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-029 cpu_hold and busy SHALL be 1 in LEN0 through DONE inclusive and 0 in IDLE.
REQ-030 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata SHALL hold their last values otherwise.
REQ-031 rx_valid gaps SHALL stall the FSM in its current state with no timeout; peak rate is 4 bytes per 5 cycles.

Reset
REQ-032 reset=0 SHALL force IDLE asynchronously, from any state including mid-load.
REQ-033 In reset, rx_ready, mem_we, cpu_hold, busy, done and err SHALL be 0, and mem_addr, mem_wdata, count, index and the byte counter SHALL be 0.
REQ-034 Memory words already written before a mid-load reset are not rolled back, and a reset SHALL NOT set err.

Structure
REQ-035 The shared package SHALL hold the state enum, the ADDR_W and LEN_W defaults, and the DATA_BYTES=4 constant.
REQ-036 One sub-module, word_assembler (byte counter plus 32-bit little-endian shift register), SHALL be instantiated; the FSM lives in prog_loader.

Verification
REQ-037 start; bytes 02 00, 13 00 00 00, 37 12 00 00 -> writes addr0=0x00000013 and addr1=0x00001237, done pulses once, cpu_hold falls the cycle after done.
REQ-038 Header 00 00 -> err=1, no mem_we, IDLE; a later start clears err.
REQ-039 Header 01 40 (16385) -> err=1, no writes; header 00 40 with 16384 words -> last write at addr 0x3FFF, then done.
REQ-040 rx_valid toggled randomly during a 3-word load -> identical writes, and rx_ready=0 in every WRITE cycle.
REQ-041 reset=0 asserted after 6 data bytes -> immediate IDLE, all outputs 0, exactly one write observed, err=0.
REQ-042 start pulsed during DATA -> ignored, and the load completes unchanged.
